// File: rtl/fpu_host_if.sv
// Host-bus front end for the FPU core: bus-width configurable operand/op
// registers, a command queue of {OP, A, B} snapshots, a status register with
// sticky overflow, and the cmd_end/end_ack completion handshake.
module fpu_host_if #(
  parameter int BUS_W  = 8,
  parameter int QDEPTH = 4,
  parameter int OP_W   = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [BUS_W-1:0]  databus_in,
  output logic [BUS_W-1:0]  databus_out,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic              end_ack,
  output logic              cmd_end,
  output logic              busy,
  output logic              core_start,
  output logic [OP_W-1:0]   core_op,
  output logic [31:0]       core_a,
  output logic [31:0]       core_b,
  input  logic              core_done,
  input  logic [31:0]       core_result
);

  localparam int WPO      = 32 / BUS_W;
  localparam int OP_AD    = 2 * WPO;
  localparam int START_AD = 2 * WPO + 1;
  localparam int RES_AD   = 2 * WPO + 1;
  localparam int STAT_AD  = 3 * WPO + 1;
  localparam int PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int ENT_W    = OP_W + 64;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              wr_q;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       res_q;
  logic [ENT_W-1:0]  q_mem [QDEPTH];
  logic [PTR_W-1:0]  hd_q, tl_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]   core_op_q;
  logic [31:0]       core_a_q, core_b_q;

  logic [31:0]       addr_w;
  logic              wr_commit;
  logic              start_commit;
  logic              q_full;
  logic              push_ok;
  logic              pop;
  logic [7:0]        status;

  // Advance a queue pointer, wrapping at the configured depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign addr_w       = 32'(addr);
  assign wr_commit    = !cs && !wr && wr_q;
  assign start_commit = wr_commit && (addr_w == 32'(START_AD));
  assign q_full       = (cnt_q == 4'(QDEPTH));
  assign push_ok      = start_commit && (!q_full || pop);
  assign busy         = (cnt_q != 4'd0) || (state_q != S_IDLE);
  assign status       = {cnt_q, ovf_q, q_full, cmd_end, busy};
  assign core_op      = core_op_q;
  assign core_a       = core_a_q;
  assign core_b       = core_b_q;

  // Next values of the host-writable operand, op and overflow registers.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    ovf_d = ovf_q;
    for (int w = 0; w < WPO; w++) begin
      if (wr_commit && addr_w == 32'(w))       a_d[w*BUS_W +: BUS_W] = databus_in;
      if (wr_commit && addr_w == 32'(WPO + w)) b_d[w*BUS_W +: BUS_W] = databus_in;
    end
    if (wr_commit && addr_w == 32'(OP_AD))   op_d  = databus_in[OP_W-1:0];
    if (wr_commit && addr_w == 32'(STAT_AD)) ovf_d = 1'b0;
    if (start_commit && q_full && !pop)      ovf_d = 1'b1;
  end

  // Host register bank and write-strobe edge detector.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      ovf_q <= ovf_d;
    end
  end

  // Queue occupancy; a push and pop in the same cycle leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Command queue storage and pointers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < QDEPTH; i++) q_mem[i] <= '0;
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        q_mem[tl_q] <= {op_q, a_q, b_q};
        tl_q        <= ptr_inc(tl_q);
      end
      if (pop) hd_q <= ptr_inc(hd_q);
      cnt_q <= cnt_d;
    end
  end

  // Command sequencer state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Sequencer next state, queue pop and handshake outputs.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    core_start = 1'b0;
    cmd_end    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != 4'd0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) state_d = S_DONE;
      end
      S_DONE: begin
        cmd_end = 1'b1;
        if (end_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Launched command operands are latched on pop; result latched on completion.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      core_op_q <= '0;
      core_a_q  <= '0;
      core_b_q  <= '0;
      res_q     <= '0;
    end else begin
      if (pop) {core_op_q, core_a_q, core_b_q} <= q_mem[hd_q];
      if (state_q == S_WAIT && core_done) res_q <= core_result;
    end
  end

  // Combinational host read mux; unmapped addresses read zero.
  always_comb begin
    databus_out = '0;
    if (!cs && !rd) begin
      for (int w = 0; w < WPO; w++) begin
        if (addr_w == 32'(w))          databus_out = a_q[w*BUS_W +: BUS_W];
        if (addr_w == 32'(WPO + w))    databus_out = b_q[w*BUS_W +: BUS_W];
        if (addr_w == 32'(RES_AD + w)) databus_out = res_q[w*BUS_W +: BUS_W];
      end
      if (addr_w == 32'(OP_AD))   databus_out[OP_W-1:0] = op_q;
      if (addr_w == 32'(STAT_AD)) databus_out[7:0]      = status;
    end
  end

endmodule

// File: tb/tb_fpu_host_if.sv
// Directed bench for fpu_host_if: an 8-bit bus instance with a delayed-reply
// core stub, and a 16-bit bus instance driven by hand.
module tb_fpu_host_if;

  localparam logic [3:0] OP_LOG2 = 4'h5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst;

  // 8-bit instance
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [3:0]  addr;
  logic        cs, rd, wr, end_ack;
  logic        cmd_end, busy, core_start;
  logic [3:0]  core_op;
  logic [31:0] core_a, core_b;
  logic [31:0] core_result;
  logic        stub_done = 1'b0;
  logic        man_done;
  logic        stub_en;
  logic        core_done;
  int          stub_dly = 0;
  int          n_starts = 0;
  assign core_done = stub_done | man_done;

  // 16-bit instance
  logic [15:0] din16, dout16;
  logic [3:0]  addr16;
  logic        cs16, rd16, wr16, ack16;
  logic        cmd_end16, busy16, start16;
  logic [3:0]  op16;
  logic [31:0] a16, b16, res16;
  logic        done16;

  int n_cmp = 0;
  int n_bad = 0;

  fpu_host_if #(.BUS_W(8), .QDEPTH(4), .OP_W(4), .ADDR_W(4)) u_dut (
    .clk(clk), .arst(arst), .databus_in(din), .databus_out(dout), .addr(addr),
    .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(cmd_end), .busy(busy),
    .core_start(core_start), .core_op(core_op), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_result(core_result)
  );

  fpu_host_if #(.BUS_W(16), .QDEPTH(4), .OP_W(4), .ADDR_W(4)) u_dut16 (
    .clk(clk), .arst(arst), .databus_in(din16), .databus_out(dout16), .addr(addr16),
    .cs(cs16), .rd(rd16), .wr(wr16), .end_ack(ack16), .cmd_end(cmd_end16), .busy(busy16),
    .core_start(start16), .core_op(op16), .core_a(a16), .core_b(b16),
    .core_done(done16), .core_result(res16)
  );

  // Core stub: answers five cycles after each launch while enabled.
  always @(negedge clk) begin
    stub_done = 1'b0;
    if (core_start) begin
      n_starts++;
      if (stub_en) stub_dly = 5;
    end else if (stub_dly > 0) begin
      stub_dly--;
      if (stub_dly == 0) stub_done = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; addr = a; din = d;
    @(posedge clk); #1;
    cs = 1'b1; wr = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0; addr = a;
    #1 d = dout;
    cs = 1'b1; rd = 1'b1;
  endtask

  task automatic wr_word(input logic [3:0] base, input logic [31:0] v);
    for (int i = 0; i < 4; i++) bus_wr(base + 4'(i), v[8*i +: 8]);
  endtask

  task automatic post(input logic [31:0] a_val);
    wr_word(4'd0, a_val);
    bus_wr(4'd9, 8'h00);
  endtask

  task automatic ack;
    @(posedge clk); #1 end_ack = 1'b1;
    @(posedge clk); #1 end_ack = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max);
    int i = 0;
    while (!cmd_end && i < max) begin
      @(posedge clk); #1;
      i++;
    end
    chk(tag, 32'(cmd_end), 32'd1);
  endtask

  task automatic wr16_t(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cs16 = 1'b0; wr16 = 1'b0; addr16 = a; din16 = d;
    @(posedge clk); #1;
    cs16 = 1'b1; wr16 = 1'b1;
  endtask

  task automatic rd16_t(input logic [3:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    cs16 = 1'b0; rd16 = 1'b0; addr16 = a;
    #1 d = dout16;
    cs16 = 1'b1; rd16 = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  r8;
    logic [15:0] r16;
    int          nst0;
    arst = 1'b1;
    cs = 1'b1; rd = 1'b1; wr = 1'b1; end_ack = 1'b0; din = '0; addr = '0;
    cs16 = 1'b1; rd16 = 1'b1; wr16 = 1'b1; ack16 = 1'b0; din16 = '0; addr16 = '0;
    core_result = '0; man_done = 1'b0; stub_en = 1'b0;
    res16 = '0; done16 = 1'b0;

    // Reset state
    cycles(3);
    chk("rst_cmd_end", 32'(cmd_end), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_core_a", core_a, 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    bus_rd(4'hD, r8);
    chk("rst_status", 32'(r8), 32'd0);
    arst = 1'b0;
    cycles(2);

    // Single operation
    stub_en = 1'b1;
    core_result = 32'h40400000;
    wr_word(4'd0, 32'h41000000);
    wr_word(4'd4, 32'h3EE839F1);
    bus_wr(4'd8, {4'h0, OP_LOG2});
    bus_wr(4'd9, 8'h00);
    chk("t1_busy_T1", 32'(busy), 32'd1);
    chk("t1_start_T1", 32'(core_start), 32'd0);
    cycles(1);
    chk("t1_start_T2", 32'(core_start), 32'd1);
    chk("t1_core_a", core_a, 32'h41000000);
    chk("t1_core_b", core_b, 32'h3EE839F1);
    chk("t1_core_op", 32'(core_op), 32'(OP_LOG2));
    cycles(1);
    chk("t1_start_T3", 32'(core_start), 32'd0);
    wait_end("t1_cmd_end", 20);
    bus_rd(4'h9, r8); chk("t1_res0", 32'(r8), 32'h00);
    bus_rd(4'hA, r8); chk("t1_res1", 32'(r8), 32'h00);
    bus_rd(4'hB, r8); chk("t1_res2", 32'(r8), 32'h40);
    bus_rd(4'hC, r8); chk("t1_res3", 32'(r8), 32'h40);
    bus_rd(4'hD, r8); chk("t1_status", 32'(r8), 32'h03);
    bus_rd(4'hE, r8); chk("t1_unmapped", 32'(r8), 32'h00);
    ack;
    chk("t1_ack_cmd_end", 32'(cmd_end), 32'd0);
    chk("t1_ack_busy", 32'(busy), 32'd0);

    // Queueing and strict serialisation
    core_result = 32'h11111111;
    post(32'h3F800000);
    post(32'h40000000);
    post(32'h41200000);
    cycles(10);
    bus_rd(4'hD, r8);
    chk("q_count_after_launch", 32'(r8[7:4]), 32'd2);
    chk("q_cmd_end_1", 32'(cmd_end), 32'd1);
    chk("q_core_a_1", core_a, 32'h3F800000);
    ack;
    wait_end("q_cmd_end_2", 30);
    chk("q_core_a_2", core_a, 32'h40000000);
    bus_rd(4'hD, r8);
    chk("q_count_2", 32'(r8[7:4]), 32'd1);
    ack;
    wait_end("q_cmd_end_3", 30);
    chk("q_core_a_3", core_a, 32'h41200000);
    ack;
    chk("q_busy_end", 32'(busy), 32'd0);

    // Overflow with the core held in WAIT
    stub_en = 1'b0;
    repeat (6) bus_wr(4'd9, 8'h00);
    bus_rd(4'hD, r8);
    chk("ovf_status", 32'(r8), 32'h4D);
    bus_wr(4'hD, 8'h00);
    bus_rd(4'hD, r8);
    chk("ovf_cleared", 32'(r8), 32'h45);
    @(posedge clk); #1 arst = 1'b1;
    cycles(1);
    arst = 1'b0;
    cycles(2);

    // Long write strobe gives exactly one push; end_ack in IDLE is ignored
    stub_en = 1'b1;
    nst0 = n_starts;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; addr = 4'd9;
    repeat (5) @(posedge clk);
    #1 cs = 1'b1; wr = 1'b1;
    wait_end("strb_cmd_end", 30);
    ack;
    cycles(5);
    chk("strb_launches", 32'(n_starts - nst0), 32'd1);
    chk("strb_busy", 32'(busy), 32'd0);
    end_ack = 1'b1;
    cycles(1);
    end_ack = 1'b0;
    cycles(1);
    chk("idle_ack_cmd_end", 32'(cmd_end), 32'd0);
    chk("idle_ack_start", 32'(core_start), 32'd0);
    bus_rd(4'hD, r8);
    chk("idle_ack_status", 32'(r8), 32'h00);

    // Reset during WAIT with two commands queued
    stub_en = 1'b0;
    wr_word(4'd0, 32'h3F800000);
    bus_wr(4'd8, {4'h0, OP_LOG2});
    repeat (3) bus_wr(4'd9, 8'h00);
    bus_rd(4'hD, r8);
    chk("mid_status_pre", 32'(r8), 32'h21);
    chk("mid_core_a_pre", core_a, 32'h3F800000);
    @(posedge clk); #1 arst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_core_a", core_a, 32'd0);
    chk("mid_rst_core_op", 32'(core_op), 32'd0);
    bus_rd(4'hD, r8);
    chk("mid_rst_status", 32'(r8), 32'h00);
    @(posedge clk); #1 arst = 1'b0;
    cycles(1);
    man_done = 1'b1;
    cycles(1);
    man_done = 1'b0;
    cycles(2);
    chk("mid_late_done_cmd_end", 32'(cmd_end), 32'd0);
    chk("mid_late_done_busy", 32'(busy), 32'd0);
    chk("mid_late_done_start", 32'(core_start), 32'd0);

    // 16-bit bus instance
    wr16_t(4'd0, 16'h890D);
    wr16_t(4'd1, 16'h4D96);
    wr16_t(4'd2, 16'h7FAD);
    wr16_t(4'd3, 16'h4A44);
    wr16_t(4'd4, 16'h0005);
    wr16_t(4'd5, 16'h0000);
    cycles(1);
    chk("w16_start", 32'(start16), 32'd1);
    chk("w16_core_a", a16, 32'h4D96890D);
    chk("w16_core_b", b16, 32'h4A447FAD);
    chk("w16_core_op", 32'(op16), 32'h5);
    cycles(1);
    res16 = 32'hC0490FDB;
    done16 = 1'b1;
    cycles(1);
    done16 = 1'b0;
    chk("w16_cmd_end", 32'(cmd_end16), 32'd1);
    rd16_t(4'd5, r16); chk("w16_res_lo", 32'(r16), 32'h0FDB);
    rd16_t(4'd6, r16); chk("w16_res_hi", 32'(r16), 32'hC049);
    rd16_t(4'd7, r16); chk("w16_status", 32'(r16), 32'h0003);
    @(posedge clk); #1 ack16 = 1'b1;
    @(posedge clk); #1 ack16 = 1'b0;
    chk("w16_ack_busy", 32'(busy16), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
